uart_mem_loader: RTL and testbench

//  Downstream consumer of the UART RX FIFO and upstream producer for its TX FIFO.

---
 rtl/uart_mem_loader_pkg.sv | 27 ++
 rtl/uart_word_assembler.sv | 46 ++++
 rtl/uart_mem_loader.sv | 172 +++++++++++++++++
 tb/tb_uart_mem_loader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_loader_pkg
// Purpose  : Shared state encoding and protocol byte values for the UART loader.
// Revision : 1.0 - initial release
// ============================================================================
package uart_mem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    localparam logic [7:0] c_sync = 8'hA5;
    localparam logic [7:0] c_ack  = 8'h06;
    localparam logic [7:0] c_nak  = 8'h15;

    function automatic logic [7:0] resp_byte(input logic nak);
        return nak ? c_nak : c_ack;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : uart_word_assembler
// Purpose  : Collects four bytes into a 32-bit little-endian word.
// Revision : 1.0 - initial release
// ============================================================================
module uart_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clr,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        last_byte
);

    logic [31:0] r_word;
    logic [1:0]  r_idx;
    logic [31:0] w_word;

    // word_out already contains the byte being loaded, so the consumer can
    // latch a complete word in the same cycle the final byte arrives
    always_comb begin
        w_word = r_word;
        if (load) begin
            w_word[{r_idx, 3'b000} +: 8] = byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (clr) begin
            r_idx  <= '0;
        end else if (load) begin
            r_word <= w_word;
            r_idx  <= r_idx + 2'd1;
        end
    end

    assign word_out  = w_word;
    assign last_byte = (r_idx == 2'd3);

endmodule
`default_nettype wire

// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_loader
// Purpose  : Parses framed bytes from the UART RX FIFO into memory word writes
//            and answers each frame with an ACK/NAK byte on the TX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 5000000,
    parameter int TO_BITS   = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0]  c_base    = ADDR_W'(BASE_ADDR);
    localparam logic [TO_BITS-1:0] c_to_last = TO_BITS'(TIMEOUT - 1);

    state_t              r_state;
    logic [7:0]          r_len_lo;
    logic [15:0]         r_words_left;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [TO_BITS-1:0]  r_to_cnt;
    logic                r_mem_we;
    logic [31:0]         r_mem_wdata;
    logic                r_err;
    logic                r_busy;
    logic                r_nak;
    logic [7:0]          r_w_data;

    logic                w_consume;
    logic                w_timed;
    logic                w_pop;
    logic                w_push;
    logic                w_timeout;
    logic [7:0]          w_resp;
    logic [31:0]         w_asm_word;
    logic                w_asm_last;

    assign w_timed   = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA);
    assign w_consume = (r_state == S_IDLE) || w_timed;
    // Strobes are gated by reset so nothing leaks out while reset is held
    assign w_pop     = reset && w_consume && !rx_empty;
    assign w_push    = reset && (r_state == S_RESP) && !tx_full;
    assign w_timeout = w_timed && rx_empty && (r_to_cnt == c_to_last);
    assign w_resp    = resp_byte(r_nak);

    uart_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .load      (w_pop && (r_state == S_DATA)),
        .clr       (r_state != S_DATA),
        .byte_in   (r_data),
        .word_out  (w_asm_word),
        .last_byte (w_asm_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_len_lo     <= '0;
            r_words_left <= '0;
            r_mem_addr   <= c_base;
            r_to_cnt     <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_nak        <= 1'b0;
            r_w_data     <= '0;
        end else begin
            r_mem_we <= 1'b0;

            if (w_timed && rx_empty) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end

            if (w_push) begin
                r_w_data <= w_resp;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop && (r_data == c_sync)) begin
                        r_state <= S_LEN_LO;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (w_pop) begin
                        r_len_lo <= r_data;
                        r_state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_pop) begin
                        r_words_left <= {r_data, r_len_lo};
                        if ({r_data, r_len_lo} == 16'd0) begin
                            r_nak   <= 1'b0;
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_pop && w_asm_last) begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_asm_word;
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_mem_addr   <= r_mem_addr + 1'b1;
                    r_words_left <= r_words_left - 16'd1;
                    if (r_words_left == 16'd1) begin
                        r_nak   <= 1'b0;
                        r_state <= S_RESP;
                    end else begin
                        r_state <= S_DATA;
                    end
                end
                S_RESP: begin
                    if (w_push) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_mem_addr <= c_base;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A stalled frame is abandoned; words already written are kept
            if (w_timeout) begin
                r_state <= S_RESP;
                r_nak   <= 1'b1;
                r_err   <= 1'b1;
            end
        end
    end

    assign rd_uart   = w_pop;
    assign wr_uart   = w_push;
    assign w_data    = w_push ? w_resp : r_w_data;
    assign done      = w_push && !r_nak;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mem_loader
// Purpose  : Randomized scoreboard bench for uart_mem_loader with a frame-level
//            reference model. Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mem_loader;

    localparam int ADDR_W    = 2;
    localparam int BASE_ADDR = 0;
    localparam int TIMEOUT   = 300;
    localparam int TO_BITS   = 9;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } mem_exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_empty;
    logic [7:0]        r_data;
    logic              rd_uart;
    logic              tx_full;
    logic [7:0]        w_data;
    logic              wr_uart;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;

    logic [7:0] rx_q[$];
    logic [7:0] stim_q[$];
    mem_exp_t   exp_mem[$];
    logic [7:0] exp_tx[$];
    logic       m_err;
    logic       tx_rand = 1'b0;
    int         checks = 0;
    int         failures = 0;

    uart_mem_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .TIMEOUT   (TIMEOUT),
        .TO_BITS   (TO_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .w_data    (w_data),
        .wr_uart   (wr_uart),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic rx_refresh();
        rx_empty = (rx_q.size() == 0);
        if (rx_q.size() != 0) r_data = rx_q[0];
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_q.push_back(b);
        rx_refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // RX FIFO model: a pop seen at the edge takes effect just after it
    always @(posedge clk) begin : fifo_pop
        logic p;
        p = rd_uart;
        #1;
        if (p && rx_q.size() != 0) rx_q.delete(0);
        rx_refresh();
    end

    always @(posedge clk) begin : tx_backpressure
        #2;
        if (tx_rand) tx_full = ($urandom_range(0, 3) == 0);
    end

    // Frame-level reference: hunt SYNC, read length, slice words, ACK or NAK
    function automatic void model_stream();
        int i;
        int n;
        logic [31:0] wd;
        mem_exp_t e;
        i = 0;
        while (i < stim_q.size()) begin
            if (stim_q[i] != 8'hA5) begin
                i++;
            end else begin
                i++;
                m_err = 1'b0;
                if (i + 2 > stim_q.size()) begin
                    exp_tx.push_back(8'h15);
                    m_err = 1'b1;
                    return;
                end
                n = int'({stim_q[i+1], stim_q[i]});
                i += 2;
                for (int w = 0; w < n; w++) begin
                    if (i + 4 > stim_q.size()) begin
                        exp_tx.push_back(8'h15);
                        m_err = 1'b1;
                        return;
                    end
                    wd = {stim_q[i+3], stim_q[i+2], stim_q[i+1], stim_q[i]};
                    e.addr = ADDR_W'((BASE_ADDR + w) % (1 << ADDR_W));
                    e.data = wd;
                    exp_mem.push_back(e);
                    i += 4;
                end
                exp_tx.push_back(8'h06);
            end
        end
    endfunction

    task automatic send_raw();
        foreach (stim_q[k]) begin
            repeat ($urandom_range(0, 3)) tick();
            push_byte(stim_q[k]);
        end
    endtask

    task automatic send_stream();
        model_stream();
        send_raw();
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (rx_q.size() == 0 && exp_mem.size() == 0 && exp_tx.size() == 0 && !busy) begin
                check({name, "_err"}, 32'(err), 32'(m_err));
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL %s_idle_timeout pending_mem=%0d pending_tx=%0d busy=%0b", name,
                 exp_mem.size(), exp_tx.size(), busy);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rd_uart"},   32'(rd_uart),   32'd0);
        check({name, "_wr_uart"},   32'(wr_uart),   32'd0);
        check({name, "_w_data"},    32'(w_data),    32'd0);
        check({name, "_mem_we"},    32'(mem_we),    32'd0);
        check({name, "_mem_addr"},  32'(mem_addr),  32'(BASE_ADDR));
        check({name, "_mem_wdata"}, mem_wdata,      32'd0);
        check({name, "_busy"},      32'(busy),      32'd0);
        check({name, "_done"},      32'(done),      32'd0);
        check({name, "_err"},       32'(err),       32'd0);
    endtask

    always @(negedge clk) begin : monitor
        mem_exp_t em;
        logic [7:0] et;
        if (reset) begin
            if (rd_uart) check("pop_while_empty", 32'(rx_empty), 32'd0);
            if (wr_uart) check("push_while_full", 32'(tx_full), 32'd0);
            if (mem_we) begin
                if (exp_mem.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_mem_we addr=%0h data=%0h expected none", mem_addr, mem_wdata);
                end else begin
                    em = exp_mem.pop_front();
                    check("mem_addr", 32'(mem_addr), 32'(em.addr));
                    check("mem_wdata", mem_wdata, em.data);
                end
            end
            if (wr_uart) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tx_push w_data=%0h expected none", w_data);
                end else begin
                    et = exp_tx.pop_front();
                    check("tx_byte", 32'(w_data), 32'(et));
                    check("done_pulse", 32'(done), 32'(et == 8'h06));
                end
            end else if (done) begin
                check("done_without_push", 32'(done), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        reset   = 1'b0;
        tx_full = 1'b0;
        rx_empty = 1'b1;
        r_data  = 8'h00;
        m_err   = 1'b0;
        push_byte(8'h00);
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        tick();
        reset = 1'b1;
        wait_idle("por_flush", 200);

        stim_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_stream();
        wait_idle("two_words", 500);

        stim_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
        send_stream();
        wait_idle("hunt_zero_len", 500);

        stim_q = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
        send_stream();
        wait_idle("timeout_nak", 2000);
        stim_q = '{8'hA5, 8'h00, 8'h00};
        send_stream();
        wait_idle("err_clear", 500);

        tick();
        tx_full = 1'b1;
        stim_q = '{8'hA5, 8'h00, 8'h00};
        send_stream();
        repeat (55) @(negedge clk);
        check("held_resp_pending", 32'(exp_tx.size()), 32'd1);
        check("held_resp_busy", 32'(busy), 32'd1);
        tick();
        tx_full = 1'b0;
        wait_idle("tx_full_release", 200);

        stim_q = '{8'hA5, 8'h05, 8'h00};
        for (int w = 0; w < 20; w++) stim_q.push_back(8'($urandom_range(0, 255)));
        send_stream();
        wait_idle("addr_wrap", 1000);

        stim_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_raw();
        repeat (4) tick();
        check("mid_frame_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("mid_reset");
        tick();
        reset = 1'b1;
        m_err = 1'b0;
        stim_q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_stream();
        wait_idle("after_reset", 500);

        tx_rand = 1'b1;
        for (int s = 0; s < 20; s++) begin
            stim_q.delete();
            repeat ($urandom_range(0, 2)) stim_q.push_back(8'($urandom_range(0, 255)));
            stim_q.push_back(8'hA5);
            n = $urandom_range(0, 4);
            stim_q.push_back(8'(n));
            stim_q.push_back(8'h00);
            repeat (4 * n) stim_q.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) if (stim_q.size() > 1) stim_q.pop_back();
            end
            send_stream();
            wait_idle("random", 3000);
        end
        tx_rand = 1'b0;
        tick();
        tx_full = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
